// File: rtl/pc_vector_sequencer.sv
// Fetches the RESET/NMI/IRQ/BRK vector (low byte, then high byte) and loads it into the PC.
// A request seen in IDLE loads the PC on the 4th ph2 step; rdy=0 freezes every step and holds all outputs.
module pc_vector_sequencer #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic        sys_clock,
    input  logic        rst,
    input  logic        clk_ph2,
    input  logic        rdy,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        brk_req,
    input  logic [7:0]  data_in,
    output logic [15:0] vec_addr,
    output logic        vec_rd,
    output logic [7:0]  adl_out,
    output logic [7:0]  adh_out,
    output logic        adl_load_en,
    output logic        adh_load_en,
    output logic        pc_inc_en,
    output logic        busy,
    output logic        seq_done,
    output logic [1:0]  src
);

    typedef enum logic [2:0] {
        ST_START,
        ST_IDLE,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_LOAD
    } state_t;

    localparam logic [1:0] SRC_RST = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_IRQ = 2'd2;
    localparam logic [1:0] SRC_BRK = 2'd3;

    state_t      r_state;
    logic        r_nmi_prev;
    logic        r_nmi_pend;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [1:0]  r_src;
    logic [15:0] r_vec_addr;
    logic        r_vec_rd;
    logic [7:0]  r_adl_out;
    logic [7:0]  r_adh_out;
    logic        r_adl_load_en;
    logic        r_adh_load_en;
    logic        r_pc_inc_en;
    logic        r_busy;
    logic        r_seq_done;

    logic        w_step;
    logic        w_nmi_edge;
    logic        w_irq_req;
    logic        w_req;
    logic [1:0]  w_req_src;

    function automatic logic [15:0] vec_of(input logic [1:0] s);
        case (s)
            SRC_RST: vec_of = VEC_RST;
            SRC_NMI: vec_of = VEC_NMI;
            default: vec_of = VEC_IRQ;
        endcase
    endfunction

    assign w_step     = clk_ph2 & rdy;
    assign w_nmi_edge = r_nmi_prev & ~nmi_n;
    assign w_irq_req  = ~irq_n & ~i_flag;

    always_comb begin
        w_req     = 1'b1;
        w_req_src = SRC_IRQ;
        if (r_nmi_pend) begin
            w_req_src = SRC_NMI;
        end else if (brk_req) begin
            w_req_src = SRC_BRK;
        end else if (w_irq_req) begin
            w_req_src = SRC_IRQ;
        end else begin
            w_req = 1'b0;
        end
    end

    // NMI edge capture runs every sys_clock, independent of ph2/rdy; a new edge beats the service clear.
    always_ff @(posedge sys_clock) begin
        r_nmi_prev <= nmi_n;
        if (!rst) begin
            r_nmi_pend <= 1'b0;
        end else if (w_nmi_edge) begin
            r_nmi_pend <= 1'b1;
        end else if (w_step && (r_state == ST_IDLE) && r_nmi_pend) begin
            r_nmi_pend <= 1'b0;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (!rst) begin
            r_state       <= ST_START;
            r_lo          <= 8'h00;
            r_hi          <= 8'h00;
            r_src         <= SRC_RST;
            r_vec_addr    <= 16'h0000;
            r_vec_rd      <= 1'b0;
            r_adl_out     <= 8'h00;
            r_adh_out     <= 8'h00;
            r_adl_load_en <= 1'b0;
            r_adh_load_en <= 1'b0;
            r_pc_inc_en   <= 1'b0;
            r_busy        <= 1'b1;
            r_seq_done    <= 1'b0;
        end else if (w_step) begin
            r_seq_done    <= 1'b0;
            r_vec_rd      <= 1'b0;
            r_adl_load_en <= 1'b0;
            r_adh_load_en <= 1'b0;
            case (r_state)
                ST_START: begin
                    r_state     <= ST_FETCH_LO;
                    r_src       <= SRC_RST;
                    r_vec_addr  <= VEC_RST;
                    r_vec_rd    <= 1'b1;
                    r_busy      <= 1'b1;
                    r_pc_inc_en <= 1'b0;
                end
                ST_IDLE: begin
                    if (w_req) begin
                        r_state     <= ST_FETCH_LO;
                        r_src       <= w_req_src;
                        r_vec_addr  <= vec_of(w_req_src);
                        r_vec_rd    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pc_inc_en <= 1'b0;
                    end
                end
                ST_FETCH_LO: begin
                    r_lo       <= data_in;
                    r_state    <= ST_FETCH_HI;
                    r_vec_addr <= vec_of(r_src) + 16'd1;
                    r_vec_rd   <= 1'b1;
                end
                ST_FETCH_HI: begin
                    // The high byte goes straight to ADH so LOAD presents both bytes at once.
                    r_hi          <= data_in;
                    r_state       <= ST_LOAD;
                    r_adl_out     <= r_lo;
                    r_adh_out     <= data_in;
                    r_adl_load_en <= 1'b1;
                    r_adh_load_en <= 1'b1;
                end
                ST_LOAD: begin
                    r_state     <= ST_IDLE;
                    r_seq_done  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_pc_inc_en <= 1'b1;
                end
                default: begin
                    r_state     <= ST_START;
                    r_busy      <= 1'b1;
                    r_pc_inc_en <= 1'b0;
                end
            endcase
        end
    end

    assign vec_addr    = r_vec_addr;
    assign vec_rd      = r_vec_rd;
    assign adl_out     = r_adl_out;
    assign adh_out     = r_adh_out;
    assign adl_load_en = r_adl_load_en;
    assign adh_load_en = r_adh_load_en;
    assign pc_inc_en   = r_pc_inc_en;
    assign busy        = r_busy;
    assign seq_done    = r_seq_done;
    assign src         = r_src;

endmodule

// File: tb/tb_pc_vector_sequencer.sv
// Drives directed vector sequences then random traffic; every cycle is compared with a transaction-level model.
module tb_pc_vector_sequencer;

    logic        sys_clock = 1'b0;
    logic        rst;
    logic        clk_ph2;
    logic        rdy;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic        brk_req;
    logic [7:0]  data_in;
    logic [15:0] vec_addr;
    logic        vec_rd;
    logic [7:0]  adl_out;
    logic [7:0]  adh_out;
    logic        adl_load_en;
    logic        adh_load_en;
    logic        pc_inc_en;
    logic        busy;
    logic        seq_done;
    logic [1:0]  src;

    pc_vector_sequencer dut (
        .sys_clock   (sys_clock),
        .rst         (rst),
        .clk_ph2     (clk_ph2),
        .rdy         (rdy),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .i_flag      (i_flag),
        .brk_req     (brk_req),
        .data_in     (data_in),
        .vec_addr    (vec_addr),
        .vec_rd      (vec_rd),
        .adl_out     (adl_out),
        .adh_out     (adh_out),
        .adl_load_en (adl_load_en),
        .adh_load_en (adh_load_en),
        .pc_inc_en   (pc_inc_en),
        .busy        (busy),
        .seq_done    (seq_done),
        .src         (src)
    );

    always #5 sys_clock = ~sys_clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rand_mode = 0;

    // Vector memory FFFA..FFFF; anything else reads as zero.
    logic [7:0] mem [6];
    logic [15:0] pc = 16'h0000;

    // Model: m_pos is the position within a vector sequence (0 = low byte, 1 = high byte, 2 = PC load),
    // -1 when idle and -2 before the first sequence after reset.
    int          m_pos = -2;
    int          m_src = 0;
    bit          m_pend = 0;
    bit          m_nmi_prev = 1;
    bit          m_done = 0;
    logic [7:0]  m_lo = 0, m_hi = 0, m_adl = 0, m_adh = 0;
    logic [15:0] m_vaddr = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a >= 16'hFFFA) return mem[int'(a - 16'hFFFA)];
        return 8'h00;
    endfunction

    function automatic logic [15:0] vec_of(input int s);
        case (s)
            0: return 16'hFFFC;
            1: return 16'hFFFA;
            default: return 16'hFFFE;
        endcase
    endfunction

    task automatic model_step();
        bit edge_seen;
        int req;
        logic [15:0] v;
        edge_seen  = m_nmi_prev && !nmi_n;
        m_nmi_prev = nmi_n;
        if (!rst) begin
            m_pos = -2; m_src = 0; m_pend = 0; m_done = 0;
            m_lo = 0; m_hi = 0; m_adl = 0; m_adh = 0; m_vaddr = 0;
            return;
        end
        if (clk_ph2 && rdy) begin
            m_done = 0;
            v = vec_of(m_src);
            case (m_pos)
                -2: begin m_src = 0; m_pos = 0; end
                -1: begin
                    req = m_pend ? 1 : brk_req ? 3 : (!irq_n && !i_flag) ? 2 : -1;
                    if (req >= 0) begin
                        m_src = req;
                        m_pos = 0;
                        if (req == 1) m_pend = 0;
                    end
                end
                0: begin m_lo = mem_rd(v); m_pos = 1; end
                1: begin
                    m_hi  = mem_rd(v + 16'd1);
                    m_adl = m_lo;
                    m_adh = m_hi;
                    m_pos = 2;
                end
                default: begin m_pos = -1; m_done = 1; end
            endcase
            if (m_pos == 0 || m_pos == 1) m_vaddr = vec_of(m_src) + 16'(m_pos);
        end
        if (edge_seen) m_pend = 1;
    endtask

    task automatic tick();
        bit        cap;
        logic [15:0] nxt;
        if (!rand_mode) clk_ph2 = (cyc % 2 == 1);
        data_in = mem_rd(vec_addr);
        model_step();
        cap = clk_ph2 && rdy && rst && adl_load_en && adh_load_en;
        nxt = {adh_out, adl_out};
        @(posedge sys_clock);
        #1;
        if (cap) pc = nxt;
        cyc++;
        chk_val("vec_addr", vec_addr, m_vaddr);
        chk_val("vec_rd", vec_rd, (m_pos == 0 || m_pos == 1));
        chk_val("adl_out", adl_out, m_adl);
        chk_val("adh_out", adh_out, m_adh);
        chk_val("adl_load_en", adl_load_en, (m_pos == 2));
        chk_val("adh_load_en", adh_load_en, (m_pos == 2));
        chk_val("pc_inc_en", pc_inc_en, (m_pos == -1));
        chk_val("busy", busy, (m_pos != -1));
        chk_val("seq_done", seq_done, m_done);
        chk_val("src", src, m_src);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!seq_done && n < lim) begin tick(); n++; end
        chk_val("done_seen", seq_done, 1'b1);
    endtask

    task automatic wait_fetch(input logic [15:0] a, input int lim);
        int n = 0;
        while (!(vec_rd && vec_addr == a) && n < lim) begin tick(); n++; end
        chk_val("fetch_seen", {vec_rd, vec_addr}, {1'b1, a});
    endtask

    initial begin
        int n;
        rst = 1'b0; clk_ph2 = 1'b0; rdy = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
        i_flag = 1'b1; brk_req = 1'b0; data_in = 8'h00;
        mem[0] = 8'h00; mem[1] = 8'hC0; mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'h78; mem[5] = 8'h56;

        // Reset state and RESET vector fetch
        repeat (4) tick();
        chk_val("rst_busy", busy, 1'b1);
        chk_val("rst_vec_addr", vec_addr, 16'h0000);
        rst = 1'b1;
        wait_fetch(16'hFFFC, 6);
        wait_fetch(16'hFFFD, 6);
        wait_done(10);
        chk_val("rst_pc", pc, 16'h1234);
        chk_val("rst_src", src, 2'd0);

        // NMI from idle
        repeat (4) tick();
        nmi_n = 1'b0;
        wait_done(16);
        chk_val("nmi_pc", pc, 16'hC000);
        chk_val("nmi_src", src, 2'd1);
        nmi_n = 1'b1;
        repeat (8) tick();
        chk_val("nmi_cleared", busy, 1'b0);

        // Masked IRQ, then unmasked
        irq_n = 1'b0;
        repeat (10) tick();
        chk_val("irq_masked", busy, 1'b0);
        i_flag = 1'b0;
        repeat (2) tick();
        irq_n = 1'b1; i_flag = 1'b1;
        wait_done(12);
        chk_val("irq_src", src, 2'd2);
        chk_val("irq_pc", pc, 16'h5678);

        // BRK beats IRQ; NMI edge during its high-byte fetch follows after one idle step
        mem[0] = 8'h11; mem[1] = 8'h22;
        brk_req = 1'b1; irq_n = 1'b0; i_flag = 1'b0;
        repeat (2) tick();
        brk_req = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
        wait_fetch(16'hFFFF, 6);
        nmi_n = 1'b0;
        wait_done(10);
        chk_val("brk_src", src, 2'd3);
        n = 0;
        while (!vec_rd && n < 10) begin tick(); n++; end
        chk_val("idle_ticks", n, 2);
        chk_val("nmi2_addr", vec_addr, 16'hFFFA);
        nmi_n = 1'b1;
        wait_done(10);
        chk_val("nmi2_pc", pc, 16'h2211);

        // rdy stall during the high-byte fetch; low byte memory changes must not leak in
        mem[4] = 8'h9A; mem[5] = 8'hBC;
        irq_n = 1'b0; i_flag = 1'b0;
        repeat (2) tick();
        irq_n = 1'b1; i_flag = 1'b1;
        wait_fetch(16'hFFFF, 6);
        rdy = 1'b0;
        mem[4] = 8'hEE;
        repeat (6) tick();
        chk_val("stall_addr", vec_addr, 16'hFFFF);
        chk_val("stall_busy", busy, 1'b1);
        rdy = 1'b1;
        wait_done(10);
        chk_val("stall_pc", pc, 16'hBC9A);

        // Reset aborting an IRQ fetch restarts with the RESET vector
        mem[2] = 8'hCD; mem[3] = 8'hAB;
        irq_n = 1'b0; i_flag = 1'b0;
        wait_fetch(16'hFFFE, 8);
        rst = 1'b0;
        tick();
        chk_val("abort_vec_addr", vec_addr, 16'h0000);
        chk_val("abort_src", src, 2'd0);
        chk_val("abort_rd", vec_rd, 1'b0);
        rst = 1'b1;
        wait_fetch(16'hFFFC, 6);
        irq_n = 1'b1; i_flag = 1'b1;
        wait_done(10);
        chk_val("abort_pc", pc, 16'hABCD);

        // Random traffic against the model
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            clk_ph2 = ($urandom % 3 == 0);
            rdy     = ($urandom % 5 != 0);
            if ($urandom % 12 == 0) nmi_n = ~nmi_n;
            if ($urandom % 10 == 0) irq_n = ~irq_n;
            if ($urandom % 15 == 0) i_flag = ~i_flag;
            brk_req = ($urandom % 10 == 0);
            rst     = ($urandom % 400 != 0);
            if ($urandom % 40 == 0) mem[$urandom % 6] = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
